// File: rtl/vx_commit_arbiter.sv
// Writeback commit arbiter: round-robin selection among functional-unit results,
// one registered writeback per cycle, plus committed/retired counters for the CSR unit.
module vx_commit_arbiter #(
  parameter int NUM_REQS    = 5,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int UUID_BITS   = 44,
  parameter int DATA_WIDTH  = 32,
  parameter int CTR_BITS    = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_REQS-1:0]                     src_valid,
  output logic [NUM_REQS-1:0]                     src_ready,
  input  logic [NUM_REQS*UUID_BITS-1:0]           src_uuid,
  input  logic [NUM_REQS*NW_BITS-1:0]             src_wid,
  input  logic [NUM_REQS*32-1:0]                  src_PC,
  input  logic [NUM_REQS*NUM_THREADS-1:0]         src_tmask,
  input  logic [NUM_REQS-1:0]                     src_wb,
  input  logic [NUM_REQS*NR_BITS-1:0]             src_rd,
  input  logic [NUM_REQS*NUM_THREADS*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_REQS-1:0]                     src_eop,
  output logic                                    wb_valid,
  output logic [UUID_BITS-1:0]                    wb_uuid,
  output logic [NW_BITS-1:0]                      wb_wid,
  output logic [31:0]                             wb_PC,
  output logic [NUM_THREADS-1:0]                  wb_tmask,
  output logic [NR_BITS-1:0]                      wb_rd,
  output logic [NUM_THREADS*DATA_WIDTH-1:0]       wb_data,
  output logic                                    wb_eop,
  output logic [CTR_BITS-1:0]                     commit_count,
  output logic [CTR_BITS-1:0]                     instret_count
);

  localparam int IDX_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int LANE_W = NUM_THREADS * DATA_WIDTH;

  logic [IDX_W-1:0]       prio;
  logic [IDX_W-1:0]       prio_next;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_found;

  logic [UUID_BITS-1:0]   uuid_arr  [NUM_REQS];
  logic [NW_BITS-1:0]     wid_arr   [NUM_REQS];
  logic [31:0]            pc_arr    [NUM_REQS];
  logic [NUM_THREADS-1:0] tmask_arr [NUM_REQS];
  logic [NR_BITS-1:0]     rd_arr    [NUM_REQS];
  logic [LANE_W-1:0]      data_arr  [NUM_REQS];

  logic                   sel_wb;
  logic                   sel_eop;
  logic [CTR_BITS-1:0]    sel_pop;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
    assign uuid_arr[i]  = src_uuid[i*UUID_BITS +: UUID_BITS];
    assign wid_arr[i]   = src_wid[i*NW_BITS +: NW_BITS];
    assign pc_arr[i]    = src_PC[i*32 +: 32];
    assign tmask_arr[i] = src_tmask[i*NUM_THREADS +: NUM_THREADS];
    assign rd_arr[i]    = src_rd[i*NR_BITS +: NR_BITS];
    assign data_arr[i]  = src_data[i*LANE_W +: LANE_W];
  end

  function automatic logic [CTR_BITS-1:0] count_ones(input logic [NUM_THREADS-1:0] m);
    logic [CTR_BITS-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      n = n + CTR_BITS'(m[i]);
    end
    return n;
  endfunction

  // First valid source scanning upward from prio with wraparound.
  always_comb begin : grant_search
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = int'(prio) + k;
      if (cand >= NUM_REQS) begin
        cand = cand - NUM_REQS;
      end
      cand_idx = IDX_W'(cand);
      if (!grant_found && src_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (grant_found) begin
      src_ready[grant_idx] = 1'b1;
    end
  end

  assign prio_next = (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + IDX_W'(1);
  assign sel_wb    = src_wb[grant_idx];
  assign sel_eop   = src_eop[grant_idx];
  assign sel_pop   = count_ones(tmask_arr[grant_idx]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= '0;
    end else if (grant_found) begin
      prio <= prio_next;
    end
  end

  // Data fields only load on acceptance; wb_valid drops whenever nothing is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_uuid  <= '0;
      wb_wid   <= '0;
      wb_PC    <= '0;
      wb_tmask <= '0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_eop   <= 1'b0;
    end else begin
      wb_valid <= grant_found & sel_wb;
      if (grant_found) begin
        wb_uuid  <= uuid_arr[grant_idx];
        wb_wid   <= wid_arr[grant_idx];
        wb_PC    <= pc_arr[grant_idx];
        wb_tmask <= tmask_arr[grant_idx];
        wb_rd    <= rd_arr[grant_idx];
        wb_data  <= data_arr[grant_idx];
        wb_eop   <= sel_eop;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_count  <= '0;
      instret_count <= '0;
    end else if (grant_found && sel_eop) begin
      commit_count  <= commit_count + CTR_BITS'(1);
      instret_count <= instret_count + sel_pop;
    end
  end

  ready_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(src_ready));

endmodule
